qspi_psram_resp: RTL and testbench
==================================

Name: qspi_psram_resp

Overview:
- Synthesizable QSPI PSRAM responder (memory-side target) for the ExoTiny QSPI memory bus.
- Oversamples the bus SCK/CS/SDIO in the system clock domain and decodes quad-mode read/write commands.
- Serves them from a byte-wide internal memory port.
- Replaces the behavioural PSRAM model in FPGA bring-up, where the SoC's RAM chip-select drives on-chip BRAM.

Parameters:
- DEPTH, 16384, memory size in bytes; must be a power of two; the address wraps modulo DEPTH.
- DUMMY_CYCLES, 6, SCK cycles between the last address nibble and the first read data nibble.
- AW, $clog2(DEPTH), memory address width (derived; do not override).

Ports:
- clk_i  in  1  system clock; must run at least 8x the SCK frequency.
- rst_i  in  1  asynchronous active-high reset.
- sck_i  in  1  QSPI clock from the initiator; asynchronous to clk_i.
- cs_in  in  1  chip select, active low; asynchronous to clk_i.
- sd_i  in  4  SDIO input nibble.
- sd_o  out  4  SDIO output nibble.
- sd_oen_o  out  4  per-bit output enable; 1 = drive.
- mem_addr_o  out  AW  byte address to the memory.
- mem_re_o  out  1  read strobe; mem_rdata_i is valid on the clk_i cycle after the strobe.
- mem_rdata_i  in  8  read data.
- mem_we_o  out  1  one-cycle write strobe.
- mem_wdata_o  out  8  write data.

Behaviour:
- Single clock clk_i; asynchronous active-high reset rst_i.
- Reset values: sd_o=0, sd_oen_o=0, mem_re_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, FSM=IDLE.
- Synchronisation: sck_i, cs_in and sd_i each pass through 2-flop synchronisers. A rise/fall pulse is detected on the synced SCK.
  - All bus actions are qualified by synced cs_in=0.
  - All inputs are sampled on the SCK rise pulse.
  - Output nibbles update on the SCK fall pulse.
- Bus format: quad on all phases. Command byte = 2 nibbles, high first. Address = 24 bits = 6 nibbles, MSB first. Only addr[AW-1:0] is used.
- Commands:
  - 0xEB = quad read.
  - 0x38 = quad write.
  - Any other command goes to IGNORE.
- FSM states: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
  - IDLE -> CMD on a CS fall. A nibble counter counts within each phase.
  - CMD -> ADDR after 2 rises.
  - ADDR -> DUMMY (read) or WDATA (write) after 6 rises.
  - DUMMY: mem_re_o is pulsed one clk after entry; the returned byte is latched in the output buffer. After DUMMY_CYCLES rises -> RDATA.
  - RDATA: each SCK fall pulse drives the next nibble on sd_o, high nibble first, with sd_oen_o=4'hF.
    - Once the low nibble is driven, the address increments and mem_re_o is pulsed for the next byte.
    - The prefetch completes before the next fall because SCK is oversampled.
    - The first nibble is driven on the fall that ends the last dummy cycle.
  - WDATA: the nibble captured on rise 1 is the high nibble, rise 2 the low nibble.
    - After the low nibble, mem_we_o=1 for exactly one clk with the current address and byte, then the address increments.
- Address wrap: the address increment after byte DEPTH-1 gives 0, for both reads and writes.
- CS rise, in any state, at any point: FSM -> IDLE and sd_oen_o=0 within 3 clk of the raw cs_in edge.
  - A half-received write byte is discarded; no mem_we_o is issued.
  - No further mem_re_o is issued.
- Simultaneous CS rise and SCK edge: CS wins; the edge is ignored.
- Reset mid-transaction: immediate return to reset values. The next transfer requires a fresh CS fall.
- sd_oen_o is 0 in every state except RDATA.

Optional Feature:
- Macro: QSPI_PSRAM_RESP_CMDERR_EN.
- Defined: adds output port cmd_err_o (1 bit, reset 0).
  - Sticky: set on the clk after an unknown command byte is decoded.
  - Cleared only by rst_i.
- Undefined: the port is absent; unknown commands still go silently to IGNORE.

Decomposition:
- Package qspi_psram_resp_pkg holds:
  - command constants CMD_QREAD=8'hEB and CMD_QWRITE=8'h38;
  - state enum state_t;
  - constants ADDR_NIBBLES=6 and CMD_NIBBLES=2.
- One natural sub-module: qspi_resp_sync.
  - Contains the 2-flop synchronisers for sck/cs/sd and the SCK rise/fall pulse generation.
  - Instantiated once.

Test Plan:
- Write 0x38, addr 0x000010, data bytes A5 3C, CS high -> mem_we_o pulses with (0x0010,A5) then (0x0011,3C); sd_oen_o stays 0.
- Read 0xEB, addr 0x000010, 6 dummy cycles, 4 data cycles -> sd_o nibbles A,5,3,C. sd_oen_o=F from the fall after the 6th dummy until CS rises, then 0 within 3 clk.
- Write at addr DEPTH-1 (0x003FFF) with bytes 11 22 -> writes to 0x3FFF then 0x0000. A read back from 0x3FFF for 2 bytes returns 11,22.
- CS rises after 1 nibble of a write byte -> no mem_we_o; the next read of that address returns the old value.
- Command 0x9F followed by 10 SCK cycles -> sd_oen_o=0 throughout, and no mem_re_o/mem_we_o. With QSPI_PSRAM_RESP_CMDERR_EN defined, cmd_err_o=1 and stays 1 after CS rises.
- rst_i asserted during RDATA -> sd_oen_o=0 asynchronously. After release, a new 0xEB read returns correct data.

Source files
------------

// File: rtl/qspi_psram_resp_pkg.sv
// Shared command codes, phase lengths and FSM state encoding for the QSPI PSRAM responder.
package qspi_psram_resp_pkg;

    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;

    localparam int CMD_NIBBLES  = 2;
    localparam int ADDR_NIBBLES = 6;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/qspi_resp_sync.sv
// Brings the asynchronous QSPI pins into clk_i and turns synced SCK/CS levels into edge pulses.
module qspi_resp_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck_i,
    input  logic       cs_in,
    input  logic [3:0] sd_i,
    output logic       sck_rise_o,
    output logic       sck_fall_o,
    output logic       cs_n_o,
    output logic       cs_fall_o,
    output logic [3:0] sd_o
);

    logic [1:0] sck_sync_q;
    logic       sck_prev_q;
    logic [1:0] cs_sync_q;
    logic       cs_prev_q;
    logic [3:0] sd_meta_q;
    logic [3:0] sd_sync_q;

    // CS chain resets to "selected" so a chip select held low through reset
    // never looks like a fresh fall; a new transfer needs CS to go high first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync_q <= 2'b00;
            sck_prev_q <= 1'b0;
            cs_sync_q  <= 2'b00;
            cs_prev_q  <= 1'b0;
            sd_meta_q  <= 4'h0;
            sd_sync_q  <= 4'h0;
        end else begin
            sck_sync_q <= {sck_sync_q[0], sck_i};
            sck_prev_q <= sck_sync_q[1];
            cs_sync_q  <= {cs_sync_q[0], cs_in};
            cs_prev_q  <= cs_sync_q[1];
            sd_meta_q  <= sd_i;
            sd_sync_q  <= sd_meta_q;
        end
    end

    assign sck_rise_o = sck_sync_q[1] & ~sck_prev_q;
    assign sck_fall_o = ~sck_sync_q[1] & sck_prev_q;
    assign cs_n_o     = cs_sync_q[1];
    assign cs_fall_o  = cs_prev_q & ~cs_sync_q[1];
    assign sd_o       = sd_sync_q;

endmodule

// File: rtl/qspi_psram_resp.sv
// Quad-SPI PSRAM target serving 0xEB reads / 0x38 writes from a byte-wide memory port.
// Optional sticky unknown-command flag cmd_err_o when QSPI_PSRAM_RESP_CMDERR_EN is defined.
module qspi_psram_resp
    import qspi_psram_resp_pkg::*;
#(
    parameter int DEPTH        = 16384,
    parameter int DUMMY_CYCLES = 6,
    parameter int AW           = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sck_i,
    input  logic          cs_in,
    input  logic [3:0]    sd_i,
    output logic [3:0]    sd_o,
    output logic [3:0]    sd_oen_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_re_o,
    input  logic [7:0]    mem_rdata_i,
    output logic          mem_we_o,
`ifdef QSPI_PSRAM_RESP_CMDERR_EN
    output logic          cmd_err_o,
`endif
    output logic [7:0]    mem_wdata_o
);

    localparam int CNT_W = 8;

    logic          sck_rise;
    logic          sck_fall;
    logic          cs_n_s;
    logic          cs_fall;
    logic [3:0]    sd_s;

    state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          is_wr_q, is_wr_d;
    logic [3:0]    cmd_sh_q, cmd_sh_d;
    logic [AW-1:0] addr_sh_q, addr_sh_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    rbuf_q, rbuf_d;
    logic          rd_pend_q;
    logic [3:0]    whi_q, whi_d;
    logic [3:0]    sd_q, sd_d;
    logic [3:0]    oen_q, oen_d;
    logic          re_q, re_d;
    logic          we_q, we_d;
    logic [7:0]    wdata_q, wdata_d;

    logic [7:0]    cmd_byte;
    logic [AW-1:0] addr_full;

    qspi_resp_sync u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sck_i      (sck_i),
        .cs_in      (cs_in),
        .sd_i       (sd_i),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .cs_n_o     (cs_n_s),
        .cs_fall_o  (cs_fall),
        .sd_o       (sd_s)
    );

    assign cmd_byte  = {cmd_sh_q, sd_s};
    // Upper address nibbles shift out of the top; only addr[AW-1:0] survives.
    assign addr_full = AW'({addr_sh_q, sd_s});

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            is_wr_q   <= 1'b0;
            cmd_sh_q  <= 4'h0;
            addr_sh_q <= '0;
            addr_q    <= '0;
            rbuf_q    <= 8'h00;
            rd_pend_q <= 1'b0;
            whi_q     <= 4'h0;
            sd_q      <= 4'h0;
            oen_q     <= 4'h0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            is_wr_q   <= is_wr_d;
            cmd_sh_q  <= cmd_sh_d;
            addr_sh_q <= addr_sh_d;
            addr_q    <= addr_d;
            rbuf_q    <= rbuf_d;
            rd_pend_q <= re_q;
            whi_q     <= whi_d;
            sd_q      <= sd_d;
            oen_q     <= oen_d;
            re_q      <= re_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        is_wr_d   = is_wr_q;
        cmd_sh_d  = cmd_sh_q;
        addr_sh_d = addr_sh_q;
        addr_d    = addr_q;
        rbuf_d    = rbuf_q;
        whi_d     = whi_q;
        sd_d      = sd_q;
        oen_d     = oen_q;
        re_d      = 1'b0;
        we_d      = 1'b0;
        wdata_d   = wdata_q;

        // Memory returns data the cycle after the strobe.
        if (rd_pend_q) begin
            rbuf_d = mem_rdata_i;
        end
        // The write strobe cycle presents the current address; advance afterwards.
        if (we_q) begin
            addr_d = addr_q + AW'(1);
        end

        // Deselect overrides everything, including a coincident SCK edge.
        if (cs_n_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_sh_d = sd_s;
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(CMD_NIBBLES - 1)) begin
                            cnt_d = '0;
                            case (cmd_byte)
                                CMD_QREAD: begin
                                    state_d = ADDR;
                                    is_wr_d = 1'b0;
                                end
                                CMD_QWRITE: begin
                                    state_d = ADDR;
                                    is_wr_d = 1'b1;
                                end
                                default: state_d = IGNORE;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        addr_sh_d = addr_full;
                        cnt_d     = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ADDR_NIBBLES - 1)) begin
                            cnt_d   = '0;
                            phase_d = 1'b0;
                            addr_d  = addr_full;
                            if (is_wr_q) begin
                                state_d = WDATA;
                            end else begin
                                state_d = DUMMY;
                                re_d    = 1'b1;
                            end
                        end
                    end
                end
                DUMMY: begin
                    if (sck_rise) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                            cnt_d   = '0;
                            state_d = RDATA;
                        end
                    end
                end
                RDATA: begin
                    if (sck_fall) begin
                        oen_d   = 4'hF;
                        phase_d = ~phase_q;
                        if (!phase_q) begin
                            sd_d = rbuf_q[7:4];
                        end else begin
                            // Byte fully shifted out: prefetch the next one well before the next fall.
                            sd_d   = rbuf_q[3:0];
                            addr_d = addr_q + AW'(1);
                            re_d   = 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (sck_rise) begin
                        phase_d = ~phase_q;
                        if (!phase_q) begin
                            whi_d = sd_s;
                        end else begin
                            wdata_d = {whi_q, sd_s};
                            we_d    = 1'b1;
                        end
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end

        if (state_d != RDATA) begin
            oen_d = 4'h0;
        end
    end

`ifdef QSPI_PSRAM_RESP_CMDERR_EN
    logic cmd_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_err_q <= 1'b0;
        end else if (state_q == CMD && state_d == IGNORE) begin
            cmd_err_q <= 1'b1;
        end
    end

    assign cmd_err_o = cmd_err_q;
`endif

    assign sd_o        = sd_q;
    assign sd_oen_o    = oen_q;
    assign mem_addr_o  = addr_q;
    assign mem_re_o    = re_q;
    assign mem_we_o    = we_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_qspi_psram_resp.sv
// Bench for qspi_psram_resp: bit-banged quad initiator, BRAM stand-in and write/read scoreboards.
`timescale 1ns/1ps
module tb_qspi_psram_resp;

    localparam int DEPTH = 16384;
    localparam int AW    = 14;
    localparam int DUMMY = 6;
    localparam int HALF  = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          sck_i;
    logic          cs_in;
    logic [3:0]    sd_i;
    logic [3:0]    sd_o;
    logic [3:0]    sd_oen_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_re_o;
    logic [7:0]    mem_rdata_i;
    logic          mem_we_o;
    logic [7:0]    mem_wdata_o;
`ifdef QSPI_PSRAM_RESP_CMDERR_EN
    logic          cmd_err_o;
`endif

    int checks;
    int errors;

    qspi_psram_resp #(.DEPTH(DEPTH), .DUMMY_CYCLES(DUMMY)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sck_i       (sck_i),
        .cs_in       (cs_in),
        .sd_i        (sd_i),
        .sd_o        (sd_o),
        .sd_oen_o    (sd_oen_o),
        .mem_addr_o  (mem_addr_o),
        .mem_re_o    (mem_re_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_we_o    (mem_we_o),
`ifdef QSPI_PSRAM_RESP_CMDERR_EN
        .cmd_err_o   (cmd_err_o),
`endif
        .mem_wdata_o (mem_wdata_o)
    );

    always #5 clk = ~clk;

    // Block RAM stand-in with registered read.
    logic [7:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        if (mem_re_o) mem_rdata_i <= mem[mem_addr_o];
    end

    // Observation side: records every write strobe and counts strobes / stray enables.
    logic [AW+7:0] obs_wr[$];
    int re_cnt;
    int we_cnt;
    int oen_bad;
    logic watch_oen;
    always @(negedge clk) begin
        if (mem_we_o) begin
            obs_wr.push_back({mem_addr_o, mem_wdata_o});
            we_cnt++;
        end
        if (mem_re_o) re_cnt++;
        if (watch_oen && sd_oen_o != 4'h0) oen_bad++;
    end

    // Expected-result scoreboards, filled when stimulus is driven.
    logic [AW+7:0] wq[$];
    logic [3:0]    rq[$];
    int            obs_ptr;

    logic [3:0] smp_sd;
    logic [3:0] smp_oen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One SCK period: drive nibble while low, sample target outputs just before the rise.
    task automatic sck_cycle(input logic [3:0] nib);
        sd_i = nib;
        repeat (HALF) @(negedge clk);
        smp_sd  = sd_o;
        smp_oen = sd_oen_o;
        sck_i = 1'b1;
        repeat (HALF) @(negedge clk);
        sck_i = 1'b0;
    endtask

    task automatic cs_start();
        @(negedge clk);
        cs_in = 1'b0;
    endtask

    task automatic cs_end();
        repeat (HALF) @(negedge clk);
        cs_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("oen_after_cs", {28'h0, sd_oen_o}, 32'h0);
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr, output int bad);
        logic [31:0] w;
        w = {cmd, addr};
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            sck_cycle(w[31 - 4 * i -: 4]);
            if (smp_oen != 4'h0) bad++;
        end
    endtask

    task automatic do_write(input logic [23:0] addr, input int n, input logic [31:0] data);
        int bad;
        logic [7:0] b;
        logic [AW-1:0] a;
        logic [AW+7:0] e;
        $display("xfer WRITE addr=%06h bytes=%0d data=%08h", addr, n, data);
        cs_start();
        send_hdr(8'h38, addr, bad);
        for (int i = 0; i < n; i++) begin
            b = data[31 - 8 * i -: 8];
            a = addr[AW-1:0] + AW'(i);
            wq.push_back({a, b});
            sck_cycle(b[7:4]);
            if (smp_oen != 4'h0) bad++;
            sck_cycle(b[3:0]);
            if (smp_oen != 4'h0) bad++;
        end
        cs_end();
        chk("wr_oen_low", bad, 0);
        chk("wr_count", obs_wr.size() - obs_ptr, n);
        while (wq.size() > 0) begin
            e = wq.pop_front();
            if (obs_ptr < obs_wr.size()) begin
                chk($sformatf("wr_addr_data@%0h", e[AW+7:8]), {18'h0, obs_wr[obs_ptr]}, {18'h0, e});
                obs_ptr++;
            end
        end
        obs_ptr = obs_wr.size();
    endtask

    task automatic do_read(input logic [23:0] addr, input int n, input logic [31:0] data);
        int bad;
        logic [7:0] b;
        logic [3:0] e;
        $display("xfer READ  addr=%06h bytes=%0d expect=%08h", addr, n, data);
        cs_start();
        send_hdr(8'hEB, addr, bad);
        for (int i = 0; i < DUMMY; i++) begin
            sck_cycle(4'($urandom_range(0, 15)));
            if (smp_oen != 4'h0) bad++;
        end
        chk("rd_pre_oen_low", bad, 0);
        for (int i = 0; i < n; i++) begin
            b = data[31 - 8 * i -: 8];
            rq.push_back(b[7:4]);
            rq.push_back(b[3:0]);
        end
        for (int k = 0; k < 2 * n; k++) begin
            sck_cycle(4'h0);
            e = rq.pop_front();
            chk($sformatf("rd_nib%0d", k), {28'h0, smp_sd}, {28'h0, e});
            chk($sformatf("rd_oen%0d", k), {28'h0, smp_oen}, 32'hF);
        end
        repeat (HALF) @(negedge clk);
        chk("rd_oen_hold", {28'h0, sd_oen_o}, 32'hF);
        cs_end();
        chk("rd_no_write", obs_wr.size() - obs_ptr, 0);
    endtask

    typedef struct {
        logic        is_wr;
        logic [23:0] addr;
        int          n;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int bad;
        int r0;
        int w0;
        vecs[0] = '{1'b1, 24'h000010, 2, 32'hA53C_0000};
        vecs[1] = '{1'b0, 24'h000010, 2, 32'hA53C_0000};
        vecs[2] = '{1'b0, 24'h000011, 1, 32'h3C00_0000};
        vecs[3] = '{1'b1, 24'h003FFF, 2, 32'h1122_0000};
        vecs[4] = '{1'b0, 24'h003FFF, 2, 32'h1122_0000};
        vecs[5] = '{1'b0, 24'h000000, 1, 32'h2200_0000};
        vecs[6] = '{1'b1, 24'hFF4020, 4, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, 24'h000020, 4, 32'hDEAD_BEEF};

        watch_oen = 1'b0;
        obs_ptr   = 0;
        rst   = 1'b1;
        sck_i = 1'b0;
        cs_in = 1'b1;
        sd_i  = 4'h0;
        repeat (5) @(negedge clk);
        chk("rst_sd_o", {28'h0, sd_o}, 32'h0);
        chk("rst_oen", {28'h0, sd_oen_o}, 32'h0);
        chk("rst_re", {31'h0, mem_re_o}, 32'h0);
        chk("rst_we", {31'h0, mem_we_o}, 32'h0);
        chk("rst_addr", {18'h0, mem_addr_o}, 32'h0);
        chk("rst_wdata", {24'h0, mem_wdata_o}, 32'h0);
`ifdef QSPI_PSRAM_RESP_CMDERR_EN
        chk("rst_cmd_err", {31'h0, cmd_err_o}, 32'h0);
`endif
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].n, vecs[i].data);
            else               do_read(vecs[i].addr, vecs[i].n, vecs[i].data);
        end

        // Write aborted after one nibble: nothing may reach memory.
        $display("xfer ABORTED WRITE addr=000010 after 1 nibble");
        cs_start();
        send_hdr(8'h38, 24'h000010, bad);
        sck_cycle(4'h7);
        cs_end();
        chk("abort_no_write", obs_wr.size() - obs_ptr, 0);
        do_read(24'h000010, 1, 32'hA500_0000);

        // Unknown command followed by 10 clocks: bus stays released, no memory traffic.
        $display("xfer UNKNOWN cmd=9f followed by 10 sck");
        r0 = re_cnt;
        w0 = we_cnt;
        oen_bad = 0;
        watch_oen = 1'b1;
        cs_start();
        sck_cycle(4'h9);
        sck_cycle(4'hF);
        for (int i = 0; i < 10; i++) sck_cycle(4'($urandom_range(0, 15)));
        cs_end();
        watch_oen = 1'b0;
        chk("ign_oen_low", oen_bad, 0);
        chk("ign_no_re", re_cnt - r0, 0);
        chk("ign_no_we", we_cnt - w0, 0);
`ifdef QSPI_PSRAM_RESP_CMDERR_EN
        chk("ign_cmd_err_sticky", {31'h0, cmd_err_o}, 32'h1);
`endif

        // Reset in the middle of a read data phase.
        $display("xfer READ addr=000020 interrupted by reset");
        cs_start();
        send_hdr(8'hEB, 24'h000020, bad);
        for (int i = 0; i < DUMMY; i++) sck_cycle(4'h0);
        sck_cycle(4'h0);
        chk("rst_rd_nib0", {28'h0, smp_sd}, 32'hD);
        sck_cycle(4'h0);
        chk("rst_rd_nib1", {28'h0, smp_sd}, 32'hE);
        repeat (3) @(negedge clk);
        chk("rst_rd_oen_before", {28'h0, sd_oen_o}, 32'hF);
        rst = 1'b1;
        #1;
        chk("rst_async_oen", {28'h0, sd_oen_o}, 32'h0);
        chk("rst_async_addr", {18'h0, mem_addr_o}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        r0 = re_cnt;
        oen_bad = 0;
        watch_oen = 1'b1;
        for (int i = 0; i < 4; i++) sck_cycle(4'h0);
        watch_oen = 1'b0;
        chk("post_rst_idle_oen", oen_bad, 0);
        chk("post_rst_idle_re", re_cnt - r0, 0);
        cs_end();
        do_read(24'h000020, 4, 32'hDEAD_BEEF);
`ifdef QSPI_PSRAM_RESP_CMDERR_EN
        chk("cmd_err_cleared_by_rst", {31'h0, cmd_err_o}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
